// File: rtl/frame_tracker_pkg.sv
// Shared types and defaults for the per-frame min/max tracker.
package frame_tracker_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_FRAME_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Width of a counter that must be able to hold the value frame_len.
    function automatic int cnt_width(input int frame_len);
        return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/magnitude_comparator.sv
// Unsigned magnitude comparator: exactly one of eq/gt/lt is set for a against b.
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/frame_min_max_tracker.sv
// Groups a valid/ready sample stream into frames and reports each frame's min/max.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for the first sample of a frame
// ACCUM | frame in progress, min/max tracking the samples so far
// HOLD  | frame complete, result presented until the consumer takes it
module frame_min_max_tracker
    import frame_tracker_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic             out_all_eq
);

    localparam int                CNT_W    = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  min_q, min_d;
    logic [WIDTH-1:0]  max_q, max_d;
    logic              out_valid_q, out_valid_d;

    logic min_eq, min_gt, min_lt;
    logic max_eq, max_gt, max_lt;
    logic ext_eq, ext_gt, ext_lt;
    logic unused_cmp;

    magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .eq (min_eq),
        .gt (min_gt),
        .lt (min_lt)
    );

    magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .eq (max_eq),
        .gt (max_gt),
        .lt (max_lt)
    );

    magnitude_comparator #(.WIDTH(WIDTH)) u_cmp_ext (
        .a  (min_q),
        .b  (max_q),
        .eq (ext_eq),
        .gt (ext_gt),
        .lt (ext_lt)
    );

    // Ties leave an extreme untouched, so only the strict outputs steer updates.
    assign unused_cmp = ^{min_eq, min_gt, max_eq, max_lt, ext_gt, ext_lt};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        min_d       = min_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    min_d = in_data;
                    max_d = in_data;
                    if (FRAME_LEN == 1) begin
                        state_d     = HOLD;
                        count_d     = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                        count_d = CNT_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (min_lt) min_d = in_data;
                    if (max_gt) max_d = in_data;
                    if (count_q == LAST_CNT) begin
                        state_d     = HOLD;
                        count_d     = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                count_d     = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            min_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q != HOLD);
    assign out_valid  = out_valid_q;
    assign out_min    = min_q;
    assign out_max    = max_q;
    assign out_all_eq = ext_eq;

endmodule

// File: tb/tb_frame_min_max_tracker.sv
// Directed and random frames checked against a queue-based model of per-frame extremes.
module tb_frame_min_max_tracker;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, in_ready, out_valid, out_ready, out_all_eq;
    logic [3:0] in_data, out_min, out_max;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_all_eq1;
    logic [3:0] in_data1, out_min1, out_max1;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];
    bit hold = 1'b0;

    always #5 clk = ~clk;

    frame_min_max_tracker #(.WIDTH(4), .FRAME_LEN(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max), .out_all_eq(out_all_eq)
    );

    frame_min_max_tracker #(.WIDTH(4), .FRAME_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_min(out_min1), .out_max(out_max1), .out_all_eq(out_all_eq1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the FRAME_LEN=8 instance: check against the model, then advance.
    task automatic step8(input bit v, input int d, input bit r);
        int mn, mx;
        in_valid  = v;
        in_data   = d[3:0];
        out_ready = r;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !hold});
        chk("out_valid", {31'd0, out_valid}, {31'd0, hold});
        if (hold) begin
            mn = 15;
            mx = 0;
            foreach (q[i]) begin
                if (q[i] < mn) mn = q[i];
                if (q[i] > mx) mx = q[i];
            end
            chk("out_min", {28'd0, out_min}, mn);
            chk("out_max", {28'd0, out_max}, mx);
            chk("out_all_eq", {31'd0, out_all_eq}, (mn == mx) ? 1 : 0);
        end
        if (hold && r) begin
            hold = 1'b0;
            q.delete();
        end else if (!hold && v) begin
            q.push_back(d & 15);
            if (q.size() == 8) hold = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
        chk({tag, "_all_eq"}, {31'd0, out_all_eq}, 1);
        chk({tag, "_min"}, {28'd0, out_min}, 0);
        chk({tag, "_max"}, {28'd0, out_max}, 0);
    endtask

    initial begin
        int basic[8]   = '{5, 3, 9, 0, 15, 7, 7, 2};
        int gapped[8]  = '{4, 4, 1, 1, 12, 12, 4, 1};
        bit v_r;
        int d_r;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        #12;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FRAME_LEN = 1: two back-to-back samples
        in_valid1  = 1'b1;
        in_data1   = 4'd10;
        out_ready1 = 1'b1;
        chk("f1_ready0", {31'd0, in_ready1}, 1);
        chk("f1_valid0", {31'd0, out_valid1}, 0);
        @(posedge clk); #1;
        chk("f1_valid1", {31'd0, out_valid1}, 1);
        chk("f1_min1", {28'd0, out_min1}, 10);
        chk("f1_max1", {28'd0, out_max1}, 10);
        chk("f1_eq1", {31'd0, out_all_eq1}, 1);
        chk("f1_ready1", {31'd0, in_ready1}, 0);
        in_data1 = 4'd2;
        @(posedge clk); #1;
        chk("f1_valid2", {31'd0, out_valid1}, 0);
        chk("f1_ready2", {31'd0, in_ready1}, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        chk("f1_valid3", {31'd0, out_valid1}, 1);
        chk("f1_min3", {28'd0, out_min1}, 2);
        chk("f1_max3", {28'd0, out_max1}, 2);
        chk("f1_eq3", {31'd0, out_all_eq1}, 1);
        @(posedge clk); #1;
        chk("f1_valid4", {31'd0, out_valid1}, 0);

        // Basic frame, result held for exactly one cycle
        foreach (basic[i]) step8(1'b1, basic[i], 1'b1);
        chk("basic_min", {28'd0, out_min}, 0);
        chk("basic_max", {28'd0, out_max}, 15);
        chk("basic_eq", {31'd0, out_all_eq}, 0);
        step8(1'b0, 0, 1'b1);
        step8(1'b0, 0, 1'b1);

        // All-equal frame
        repeat (8) step8(1'b1, 6, 1'b1);
        chk("alleq_eq", {31'd0, out_all_eq}, 1);
        step8(1'b0, 0, 1'b1);

        // Back-pressure with the source still offering samples
        for (int i = 0; i < 8; i++) step8(1'b1, 8 + (i % 5), 1'b0);
        repeat (10) step8(1'b1, 3, 1'b0);
        step8(1'b1, 3, 1'b1);
        step8(1'b1, 3, 1'b1);
        repeat (7) step8(1'b1, 9, 1'b1);
        step8(1'b0, 0, 1'b1);

        // Gaps and ties inside a frame
        step8(1'b1, gapped[0], 1'b1);
        repeat (3) step8(1'b0, 13, 1'b1);
        for (int i = 1; i < 8; i++) step8(1'b1, gapped[i], 1'b1);
        chk("gap_min", {28'd0, out_min}, 1);
        chk("gap_max", {28'd0, out_max}, 12);
        step8(1'b0, 0, 1'b1);

        // Reset mid-frame after three samples
        step8(1'b1, 0, 1'b1);
        step8(1'b1, 15, 1'b1);
        step8(1'b1, 1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        q.delete();
        hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step8(1'b1, 5 + (i % 3), 1'b1);
        chk("rst_frame_min", {28'd0, out_min}, 5);
        chk("rst_frame_max", {28'd0, out_max}, 7);
        step8(1'b0, 0, 1'b1);

        // Random traffic; source holds an offered sample until it is taken
        v_r = 1'b0;
        d_r = 0;
        for (int c = 0; c < 600; c++) begin
            if (!(v_r && hold)) begin
                v_r = ($urandom_range(0, 3) != 0);
                d_r = (c < 200) ? $urandom_range(6, 7) : $urandom_range(0, 15);
            end
            step8(v_r, d_r, $urandom_range(0, 2) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
